// File: rtl/delay_line_pkg.sv
// delay_line_pkg: fixed-point sample constants and the sample record shared by the filter blocks
package delay_line_pkg;
   localparam int FRAC_BITS = 16;
   localparam int INT_BITS  = 12;
   localparam int WIDTH     = 2 * (FRAC_BITS + INT_BITS) + 1;
   typedef struct packed {
      logic signed [WIDTH-1:0] data;
      logic                    valid;
   } sample_t;
endpackage

// File: rtl/delay_stage.sv
// delay_stage: one enabled register stage carrying a sample and its valid bit
module delay_stage
   import delay_line_pkg::*;
(
   input  logic    clk,
   input  logic    rst,
   input  logic    ce,
   input  logic    flush,
   input  sample_t d,
   output sample_t q
);
   // flush wins over ce; an idle enable holds the stage
   always_ff @(posedge clk or posedge rst)
      if (rst) q <= '0;
      else if (flush) q <= '0;
      else if (ce) q <= d;
endmodule

// File: rtl/delay_line.sv
// delay_line: DEPTH-stage delay with valid bits, flush, and a run-time selected output tap
module delay_line
   import delay_line_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int SEL_W = $clog2(DEPTH + 1)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    ce,
   input  logic                    flush,
   input  logic signed [WIDTH-1:0] in,
   input  logic                    in_valid,
   input  logic        [SEL_W-1:0] dly,
   output logic signed [WIDTH-1:0] out,
   output logic                    out_valid,
   output logic        [SEL_W-1:0] fill
);
   sample_t          chain [0:DEPTH];
   sample_t          tap;
   logic [SEL_W-1:0] eff;

   assign chain[0] = '{data: in, valid: in_valid};

   for (genvar k = 1; k <= DEPTH; k++) begin : g_stage
      delay_stage u_stage (
         .clk  (clk),
         .rst  (rst),
         .ce   (ce),
         .flush(flush),
         .d    (chain[k-1]),
         .q    (chain[k])
      );
   end

   assign eff = (dly == '0) ? SEL_W'(1) : (dly > SEL_W'(DEPTH)) ? SEL_W'(DEPTH) : dly;

   // tap mux reads the stage selected by the clamped delay
   always_comb begin
      tap = '0;
      for (int k = 1; k <= DEPTH; k++)
         if (eff == SEL_W'(k)) tap = chain[k];
   end

   assign out       = tap.data;
   assign out_valid = tap.valid;

   // fill tracks valid bits: one enters at stage 1, one may leave past the last stage
   always_ff @(posedge clk or posedge rst)
      if (rst) fill <= '0;
      else if (flush) fill <= '0;
      else if (ce) fill <= fill + SEL_W'(in_valid) - SEL_W'(chain[DEPTH].valid);
endmodule

// File: tb/tb_delay_line.sv
// tb_delay_line: table-driven latency/clamp/bubble/extreme cases plus stall, flush and reset sequences
module tb_delay_line;
   import delay_line_pkg::*;
   localparam int DEPTH = 4;
   localparam int SEL_W = $clog2(DEPTH + 1);

   logic                    clk = 1'b0;
   logic                    rst, ce, flush, in_valid;
   logic signed [WIDTH-1:0] in, out;
   logic                    out_valid;
   logic        [SEL_W-1:0] dly, fill;

   always #5 clk = ~clk;

   delay_line #(.DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .ce       (ce),
      .flush    (flush),
      .in       (in),
      .in_valid (in_valid),
      .dly      (dly),
      .out      (out),
      .out_valid(out_valid),
      .fill     (fill)
   );

   typedef struct {
      logic signed [WIDTH-1:0] data;
      int                      e;
   } exp_t;

   typedef struct {
      logic [SEL_W-1:0] dly;
      int               eff;
      int               n;
      bit               alt;
      bit               kind;
   } case_t;

   exp_t  sb[$];
   case_t tbl[8];
   int    n_cmp = 0;
   int    n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input logic c, input logic f, input logic v, input logic signed [WIDTH-1:0] d);
      ce = c;
      flush = f;
      in_valid = v;
      in = d;
      @(posedge clk);
      #1;
   endtask

   task automatic run_stream(input case_t tc);
      logic [DEPTH-1:0]        hist;
      logic signed [WIDTH-1:0] d;
      logic signed [WIDTH-1:0] mn;
      logic                    v;
      bit                      ev;
      exp_t                    x;
      mn = '0;
      mn[WIDTH-1] = 1'b1;
      dly = tc.dly;
      step(1, 1, 0, '0);
      sb.delete();
      hist = '0;
      for (int e = 0; e < tc.n + tc.eff; e++) begin
         v = (e < tc.n) && (!tc.alt || (e % 2 == 0));
         d = tc.kind ? ((e == 0) ? mn : -1) : WIDTH'(e + 1);
         if (v) sb.push_back('{d, e + tc.eff - 1});
         hist = {hist[DEPTH-2:0], v};
         step(1, 0, v, d);
         ev = (sb.size() > 0) && (sb[0].e == e);
         chk("out_valid", 64'(out_valid), 64'(ev));
         if (ev) begin
            x = sb.pop_front();
            chk("out_data", 64'(out), 64'(x.data));
         end
         chk("fill", 64'(fill), 64'($countones(hist)));
      end
      chk("scoreboard_drained", 64'(sb.size()), 64'(0));
   endtask

   initial begin
      logic signed [WIDTH-1:0] o;
      logic                    ov;
      logic [SEL_W-1:0]        f;
      tbl = '{
         '{3'd1, 1, 5, 1'b0, 1'b0},
         '{3'd2, 2, 5, 1'b0, 1'b0},
         '{3'd3, 3, 5, 1'b0, 1'b0},
         '{3'd4, 4, 5, 1'b0, 1'b0},
         '{3'd0, 1, 5, 1'b0, 1'b0},
         '{3'd7, 4, 5, 1'b0, 1'b0},
         '{3'd4, 4, 9, 1'b1, 1'b0},
         '{3'd3, 3, 2, 1'b0, 1'b1}
      };
      rst = 1'b1;
      ce = 1'b0;
      flush = 1'b0;
      in_valid = 1'b0;
      in = '0;
      dly = 3'd1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_out", 64'(out), 64'(0));
      chk("reset_out_valid", 64'(out_valid), 64'(0));
      chk("reset_fill", 64'(fill), 64'(0));
      rst = 1'b0;

      foreach (tbl[i]) run_stream(tbl[i]);

      dly = 3'd3;
      step(1, 1, 0, '0);
      step(1, 0, 1, 57'h0AA);
      o = out;
      ov = out_valid;
      f = fill;
      chk("stall_pre_fill", 64'(fill), 64'(1));
      for (int i = 0; i < 5; i++) begin
         step(0, 0, 1, 57'h555);
         chk("stall_out", 64'(out), 64'(o));
         chk("stall_out_valid", 64'(out_valid), 64'(ov));
         chk("stall_fill", 64'(fill), 64'(f));
      end
      step(1, 0, 0, '0);
      chk("stall_resume1_valid", 64'(out_valid), 64'(0));
      step(1, 0, 0, '0);
      chk("stall_resume2_valid", 64'(out_valid), 64'(1));
      chk("stall_resume2_out", 64'(out), 64'h0AA);

      dly = 3'd4;
      step(1, 1, 0, '0);
      for (int i = 0; i < 4; i++) step(1, 0, 1, WIDTH'(16 + i));
      chk("flush_full_fill", 64'(fill), 64'(4));
      chk("flush_full_out", 64'(out), 64'h10);
      chk("flush_full_valid", 64'(out_valid), 64'(1));
      step(1, 1, 1, 57'h123);
      chk("flush_out", 64'(out), 64'(0));
      chk("flush_out_valid", 64'(out_valid), 64'(0));
      chk("flush_fill", 64'(fill), 64'(0));
      for (int i = 0; i < 5; i++) begin
         step(1, 0, 0, '0);
         chk("post_flush_out", 64'(out), 64'(0));
         chk("post_flush_valid", 64'(out_valid), 64'(0));
      end

      dly = 3'd2;
      step(1, 1, 0, '0);
      for (int i = 0; i < 3; i++) step(1, 0, 1, WIDTH'(40 + i));
      chk("pre_reset_valid", 64'(out_valid), 64'(1));
      #3 rst = 1'b1;
      #1;
      chk("async_reset_out", 64'(out), 64'(0));
      chk("async_reset_valid", 64'(out_valid), 64'(0));
      chk("async_reset_fill", 64'(fill), 64'(0));
      #1 rst = 1'b0;
      run_stream('{3'd2, 2, 3, 1'b0, 1'b0});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
